store_buffer: RTL

// - Responder for the decode-stage data request (mem_valid/fence/addr/wdata/wstrb); initiator on the data-memory port.
// - Posts stores into a FIFO and acks them early. Serialises loads behind buffered stores. Drains on fence.
// - Sits between the decode stage and the data memory bus; one request outstanding on each side.

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - decode-side request/response and data-memory port bundle
interface store_buffer_if;
    logic        req_valid;
    logic        req_fence;
    logic        req_instr;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    // store buffer side: responder toward decode, initiator toward memory
    modport slave (
        input  req_valid, req_fence, req_instr, req_addr, req_wdata, req_wstrb,
        output resp_ready, resp_rdata,
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    // environment side: decode requester plus data memory
    modport master (
        output req_valid, req_fence, req_instr, req_addr, req_wdata, req_wstrb,
        input  resp_ready, resp_rdata,
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store FIFO between decode and data memory; STORE_BUFFER_FWD_EN enables store-to-load forwarding
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {F_IDLE, F_STQ, F_LDWAIT, F_LDBUSY, F_FENCE} front_t;
    typedef enum logic {B_IDLE, B_BUSY} back_t;

    front_t        front_q;
    back_t         back_q;
    logic [31:0]   cap_addr_q;
    logic [31:0]   cap_wdata_q;
    logic [3:0]    cap_wstrb_q;
    logic          cap_instr_q;
    logic [31:0]   fifo_addr_q [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [3:0]    fifo_strb_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          resp_ready_q;
    logic [31:0]   resp_rdata_q;
    logic          mem_valid_q;
    logic          mem_instr_q;
    logic [31:0]   mem_addr_q;
    logic [31:0]   mem_wdata_q;
    logic [3:0]    mem_wstrb_q;

    logic          retire;
    logic          enq;
    logic          ld_go;
    logic          fwd_hit;
    logic [31:0]   fwd_data;

    // head store completes on the memory port this cycle
    assign retire = (back_q == B_BUSY) && bus.mem_ready;
    // a full FIFO still accepts when the head frees its slot in the same cycle
    assign enq    = (front_q == F_STQ) && ((count_q != FULL) || retire);
    // loads only go to memory once every older store has drained
    assign ld_go  = (front_q == F_LDWAIT) && (count_q == '0) && (back_q == B_IDLE) && !retire;

`ifdef STORE_BUFFER_FWD_EN
    // youngest buffered store to the load's word; forward only if it covers the whole word
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) &&
                (fifo_addr_q[rd_ptr_q + PW'(i)][31:2] == cap_addr_q[31:2])) begin
                fwd_hit  = (fifo_strb_q[rd_ptr_q + PW'(i)] == 4'hF);
                fwd_data = fifo_data_q[rd_ptr_q + PW'(i)];
            end
        end
    end
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    // front (decode) FSM, back (drain) FSM, FIFO storage and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            front_q      <= F_IDLE;
            back_q       <= B_IDLE;
            cap_addr_q   <= '0;
            cap_wdata_q  <= '0;
            cap_wstrb_q  <= '0;
            cap_instr_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            resp_ready_q <= 1'b0;
            resp_rdata_q <= '0;
            mem_valid_q  <= 1'b0;
            mem_instr_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
        end else begin
            resp_ready_q <= 1'b0;
            resp_rdata_q <= '0;

            case (front_q)
                F_IDLE: begin
                    if (bus.req_fence) begin
                        front_q <= F_FENCE;
                    end else if (bus.req_valid) begin
                        cap_addr_q  <= bus.req_addr;
                        cap_wdata_q <= bus.req_wdata;
                        cap_wstrb_q <= bus.req_wstrb;
                        cap_instr_q <= bus.req_instr;
                        front_q     <= (bus.req_wstrb != 4'h0) ? F_STQ : F_LDWAIT;
                    end
                end
                F_STQ: begin
                    if (enq) begin
                        resp_ready_q <= 1'b1;
                        front_q      <= F_IDLE;
                    end
                end
                F_LDWAIT: begin
                    if (fwd_hit) begin
                        resp_ready_q <= 1'b1;
                        resp_rdata_q <= fwd_data;
                        front_q      <= F_IDLE;
                    end else if (ld_go) begin
                        mem_valid_q <= 1'b1;
                        mem_instr_q <= cap_instr_q;
                        mem_addr_q  <= cap_addr_q;
                        mem_wdata_q <= '0;
                        mem_wstrb_q <= 4'h0;
                        front_q     <= F_LDBUSY;
                    end
                end
                F_LDBUSY: begin
                    if (bus.mem_ready) begin
                        resp_ready_q <= 1'b1;
                        resp_rdata_q <= bus.mem_rdata;
                        mem_valid_q  <= 1'b0;
                        front_q      <= F_IDLE;
                    end
                end
                F_FENCE: begin
                    if ((count_q == '0) && (back_q == B_IDLE)) begin
                        resp_ready_q <= 1'b1;
                        front_q      <= F_IDLE;
                    end
                end
                default: front_q <= F_IDLE;
            endcase

            case (back_q)
                B_IDLE: begin
                    if ((count_q != '0) && (front_q != F_LDBUSY)) begin
                        mem_valid_q <= 1'b1;
                        mem_instr_q <= 1'b0;
                        mem_addr_q  <= fifo_addr_q[rd_ptr_q];
                        mem_wdata_q <= fifo_data_q[rd_ptr_q];
                        mem_wstrb_q <= fifo_strb_q[rd_ptr_q];
                        back_q      <= B_BUSY;
                    end
                end
                B_BUSY: begin
                    if (bus.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        rd_ptr_q    <= rd_ptr_q + PW'(1);
                        back_q      <= B_IDLE;
                    end
                end
                default: back_q <= B_IDLE;
            endcase

            if (enq) begin
                fifo_addr_q[wr_ptr_q] <= cap_addr_q;
                fifo_data_q[wr_ptr_q] <= cap_wdata_q;
                fifo_strb_q[wr_ptr_q] <= cap_wstrb_q;
                wr_ptr_q              <= wr_ptr_q + PW'(1);
            end

            if (enq && !retire) begin
                count_q <= count_q + CW'(1);
            end else if (!enq && retire) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign bus.resp_ready = resp_ready_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_valid  = mem_valid_q;
    assign bus.mem_instr  = mem_instr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_wstrb  = mem_wstrb_q;
endmodule
